// File: rtl/dvi_timing_gen_pkg.sv
// Shared 640x480@60 timing constants, widths and pixel-phase encoding for the DVI raster block.
package dvi_timing_gen_pkg;

   localparam int unsigned CtrW = 10;
   localparam int unsigned RgbW = 24;
   localparam int unsigned DviW = 12;

   // 640x480@60 from a 25 MHz pixel clock; image sits at the end of each line/frame.
   localparam int unsigned DefHTotal      = 800;
   localparam int unsigned DefHSyncStart  = 16;
   localparam int unsigned DefHSyncEnd    = 111;
   localparam int unsigned DefHImageStart = 160;
   localparam int unsigned DefVTotal      = 521;
   localparam int unsigned DefVSyncStart  = 10;
   localparam int unsigned DefVSyncEnd    = 11;
   localparam int unsigned DefVImageStart = 41;

   // Four 100 MHz cycles per pixel.
   typedef enum logic [1:0] {
      PhLo       = 2'd0,
      PhXclkRise = 2'd1,
      PhHi       = 2'd2,
      PhXclkFall = 2'd3
   } phase_e;

   // Inclusive range test on a raster counter.
   function automatic logic in_window(input logic [CtrW-1:0] val,
                                      input logic [CtrW-1:0] lo,
                                      input logic [CtrW-1:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/dvi_ddr_mux.sv
// Captures the renderer colour and drives the two 12-bit halves of each pixel onto the DVI bus.
module dvi_ddr_mux
   import dvi_timing_gen_pkg::*;
(
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            enable,
   input  logic [1:0]      phase,
   input  logic            pix_valid,
   input  logic [RgbW-1:0] pixel_rgb,
   output logic [DviW-1:0] dvi_d
);

   // Only {R,G[7:4]} is needed after phase 0; the low half goes straight out.
   logic [DviW-1:0] hold_hi_q, hold_hi_d;
   logic [DviW-1:0] dvi_d_q, dvi_d_d;

   // Half selection: phase 0 sends {G[3:0],B}, phase 2 sends {R,G[7:4]}; blanking forces zero.
   always_comb begin
      hold_hi_d = hold_hi_q;
      dvi_d_d   = dvi_d_q;
      if (!enable) begin
         hold_hi_d = '0;
         dvi_d_d   = '0;
      end else begin
         case (phase)
            PhLo: begin
               hold_hi_d = pixel_rgb[23:12];
               dvi_d_d   = pix_valid ? pixel_rgb[11:0] : '0;
            end
            PhHi: begin
               dvi_d_d = pix_valid ? hold_hi_q : '0;
            end
            default: ;
         endcase
      end
   end

   // Hold and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hold_hi_q <= '0;
         dvi_d_q   <= '0;
      end else begin
         hold_hi_q <= hold_hi_d;
         dvi_d_q   <= dvi_d_d;
      end
   end

   assign dvi_d = dvi_d_q;

endmodule

// File: rtl/dvi_timing_gen.sv
// 640x480 DVI raster generator: pixel phase divider, H/V counters, syncs, DE and XCLK.
module dvi_timing_gen
   import dvi_timing_gen_pkg::*;
#(
   parameter int unsigned H_TOTAL       = DefHTotal,
   parameter int unsigned H_SYNC_START  = DefHSyncStart,
   parameter int unsigned H_SYNC_END    = DefHSyncEnd,
   parameter int unsigned H_IMAGE_START = DefHImageStart,
   parameter int unsigned V_TOTAL       = DefVTotal,
   parameter int unsigned V_SYNC_START  = DefVSyncStart,
   parameter int unsigned V_SYNC_END    = DefVSyncEnd,
   parameter int unsigned V_IMAGE_START = DefVImageStart
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            enable,
   input  logic [RgbW-1:0] pixel_rgb,
   output logic [CtrW-1:0] hpos,
   output logic [CtrW-1:0] vpos,
   output logic            pix_valid,
   output logic            line_start,
   output logic            frame_start,
   output logic [DviW-1:0] DVI_D,
   output logic            DVI_DE,
   output logic            DVI_H,
   output logic            DVI_V,
   output logic            DVI_XCLK_P,
   output logic            DVI_XCLK_N
);

   localparam logic [CtrW-1:0] HLast     = CtrW'(H_TOTAL - 1);
   localparam logic [CtrW-1:0] HSyncLo   = CtrW'(H_SYNC_START);
   localparam logic [CtrW-1:0] HSyncHi   = CtrW'(H_SYNC_END);
   localparam logic [CtrW-1:0] HImgStart = CtrW'(H_IMAGE_START);
   localparam logic [CtrW-1:0] VLast     = CtrW'(V_TOTAL - 1);
   localparam logic [CtrW-1:0] VSyncLo   = CtrW'(V_SYNC_START);
   localparam logic [CtrW-1:0] VSyncHi   = CtrW'(V_SYNC_END);
   localparam logic [CtrW-1:0] VImgStart = CtrW'(V_IMAGE_START);

   phase_e          phase_q, phase_d;
   logic [CtrW-1:0] hctr_q, hctr_d;
   logic [CtrW-1:0] vctr_q, vctr_d;
   logic [CtrW-1:0] hpos_q, hpos_d;
   logic [CtrW-1:0] vpos_q, vpos_d;
   logic            pix_valid_q, pix_valid_d;
   logic            line_start_q, line_start_d;
   logic            frame_start_q, frame_start_d;
   logic            de_q, de_d;
   logic            hsync_n_q, hsync_n_d;
   logic            vsync_n_q, vsync_n_d;
   logic            xclk_p_q, xclk_p_d;
   logic            h_wrap, v_wrap;

   // Phase sequencing, counter advance on phase 3, sync/DE update on phase 0.
   always_comb begin
      phase_d       = phase_q;
      hctr_d        = hctr_q;
      vctr_d        = vctr_q;
      hpos_d        = hpos_q;
      vpos_d        = vpos_q;
      pix_valid_d   = pix_valid_q;
      de_d          = de_q;
      hsync_n_d     = hsync_n_q;
      vsync_n_d     = vsync_n_q;
      xclk_p_d      = xclk_p_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      h_wrap        = (hctr_q == HLast);
      v_wrap        = (vctr_q == VLast);

      if (!enable) begin
         // Idle raster: restart from phase 0 at pixel (0,0) once enabled again.
         phase_d     = PhLo;
         hctr_d      = '0;
         vctr_d      = '0;
         hpos_d      = '0;
         vpos_d      = '0;
         pix_valid_d = 1'b0;
         de_d        = 1'b0;
         hsync_n_d   = 1'b1;
         vsync_n_d   = 1'b1;
         xclk_p_d    = 1'b0;
      end else begin
         unique case (phase_q)
            PhLo: begin
               phase_d   = PhXclkRise;
               de_d      = pix_valid_q;
               hsync_n_d = ~in_window(hctr_q, HSyncLo, HSyncHi);
               vsync_n_d = ~in_window(vctr_q, VSyncLo, VSyncHi);
            end
            PhXclkRise: begin
               phase_d  = PhHi;
               xclk_p_d = 1'b1;
            end
            PhHi: begin
               phase_d = PhXclkFall;
            end
            PhXclkFall: begin
               phase_d  = PhLo;
               xclk_p_d = 1'b0;
               hctr_d   = h_wrap ? '0 : hctr_q + 1'b1;
               if (h_wrap) begin
                  vctr_d = v_wrap ? '0 : vctr_q + 1'b1;
               end
               line_start_d  = h_wrap;
               frame_start_d = h_wrap && v_wrap;
               // Position outputs follow the counters they will describe for the next 4 cycles.
               pix_valid_d = in_window(hctr_d, HImgStart, HLast) &&
                             in_window(vctr_d, VImgStart, VLast);
               hpos_d      = pix_valid_d ? hctr_d - HImgStart : '0;
               vpos_d      = pix_valid_d ? vctr_d - VImgStart : '0;
            end
            default: ;
         endcase
      end
   end

   // Raster state registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         phase_q       <= PhLo;
         hctr_q        <= '0;
         vctr_q        <= '0;
         hpos_q        <= '0;
         vpos_q        <= '0;
         pix_valid_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         de_q          <= 1'b0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         xclk_p_q      <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         hctr_q        <= hctr_d;
         vctr_q        <= vctr_d;
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         pix_valid_q   <= pix_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         de_q          <= de_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         xclk_p_q      <= xclk_p_d;
      end
   end

   dvi_ddr_mux u_ddr_mux (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .enable    (enable),
      .phase     (phase_q),
      .pix_valid (pix_valid_q),
      .pixel_rgb (pixel_rgb),
      .dvi_d     (DVI_D)
   );

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign pix_valid   = pix_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign DVI_DE      = de_q;
   assign DVI_H       = hsync_n_q;
   assign DVI_V       = vsync_n_q;
   assign DVI_XCLK_P  = xclk_p_q;
   assign DVI_XCLK_N  = ~xclk_p_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: a shrunken raster for full-frame checks plus a default 640x480 instance.
module tb_dvi_timing_gen;

   // Shrunken raster: 40 px/line, 12 lines/frame, 30x7 visible.
   localparam int unsigned SHT  = 40;
   localparam int unsigned SHSS = 4;
   localparam int unsigned SHSE = 7;
   localparam int unsigned SHIS = 10;
   localparam int unsigned SVT  = 12;
   localparam int unsigned SVSS = 2;
   localparam int unsigned SVSE = 3;
   localparam int unsigned SVIS = 5;
   localparam int          NVEC = 20;

   typedef struct packed {
      logic [9:0]  hpos;
      logic [9:0]  vpos;
      logic        valid;
      logic        ls;
      logic        fs;
      logic [11:0] d;
      logic        de;
      logic        h;
      logic        v;
      logic        xp;
      logic        xn;
   } outs_t;

   typedef struct {
      int    k;
      outs_t exp;
   } vec_t;

   logic        Clk;
   logic        Reset_n;
   logic        enable;
   logic [23:0] pixel_rgb;

   logic [9:0]  hpos, vpos;
   logic        pix_valid, line_start, frame_start;
   logic [11:0] dvi_d;
   logic        dvi_de, dvi_h, dvi_v, xclk_p, xclk_n;

   logic [9:0]  f_hpos, f_vpos;
   logic        f_pix_valid, f_line_start, f_frame_start;
   logic [11:0] f_dvi_d;
   logic        f_dvi_de, f_dvi_h, f_dvi_v, f_xclk_p, f_xclk_n;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t  vecs [NVEC];
   outs_t idle;

   dvi_timing_gen #(
      .H_TOTAL       (SHT),
      .H_SYNC_START  (SHSS),
      .H_SYNC_END    (SHSE),
      .H_IMAGE_START (SHIS),
      .V_TOTAL       (SVT),
      .V_SYNC_START  (SVSS),
      .V_SYNC_END    (SVSE),
      .V_IMAGE_START (SVIS)
   ) u_dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .enable      (enable),
      .pixel_rgb   (pixel_rgb),
      .hpos        (hpos),
      .vpos        (vpos),
      .pix_valid   (pix_valid),
      .line_start  (line_start),
      .frame_start (frame_start),
      .DVI_D       (dvi_d),
      .DVI_DE      (dvi_de),
      .DVI_H       (dvi_h),
      .DVI_V       (dvi_v),
      .DVI_XCLK_P  (xclk_p),
      .DVI_XCLK_N  (xclk_n)
   );

   dvi_timing_gen u_full (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .enable      (enable),
      .pixel_rgb   (pixel_rgb),
      .hpos        (f_hpos),
      .vpos        (f_vpos),
      .pix_valid   (f_pix_valid),
      .line_start  (f_line_start),
      .frame_start (f_frame_start),
      .DVI_D       (f_dvi_d),
      .DVI_DE      (f_dvi_de),
      .DVI_H       (f_dvi_h),
      .DVI_V       (f_dvi_v),
      .DVI_XCLK_P  (f_xclk_p),
      .DVI_XCLK_N  (f_xclk_n)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic outs_t mk(input logic [9:0] hp, input logic [9:0] vp, input logic vl,
                                input logic ls, input logic fs, input logic [11:0] d,
                                input logic de, input logic h, input logic v, input logic xp);
      outs_t o;
      o.hpos  = hp;
      o.vpos  = vp;
      o.valid = vl;
      o.ls    = ls;
      o.fs    = fs;
      o.d     = d;
      o.de    = de;
      o.h     = h;
      o.v     = v;
      o.xp    = xp;
      o.xn    = ~xp;
      return o;
   endfunction

   function automatic outs_t cur_outs();
      outs_t o;
      o.hpos  = hpos;
      o.vpos  = vpos;
      o.valid = pix_valid;
      o.ls    = line_start;
      o.fs    = frame_start;
      o.d     = dvi_d;
      o.de    = dvi_de;
      o.h     = dvi_h;
      o.v     = dvi_v;
      o.xp    = xclk_p;
      o.xn    = xclk_n;
      return o;
   endfunction

   task automatic check_outs(input string name, input outs_t exp);
      outs_t act;
      act = cur_outs();
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Runs 160 edges after a restart: XCLK rises on edge 2, first line_start exactly on edge 160.
   task automatic check_restart(input string tag);
      int first_ls;
      int fs_seen;
      first_ls = -1;
      fs_seen  = 0;
      for (int k = 1; k <= 160; k++) begin
         @(negedge Clk);
         if (k == 2) check_outs({tag, " xclk first rise"}, mk(0, 0, 0, 0, 0, 12'h000, 0, 1, 1, 1));
         if (line_start && first_ls < 0) first_ls = k;
         if (frame_start) fs_seen++;
      end
      check_int({tag, " first line_start edge"}, first_ls, 160);
      check_int({tag, " frame_start count"}, fs_seen, 0);
   endtask

   // Shrunken-instance stats over the second frame.
   int idx, de_cnt, h_lo, v_lo, ls_cnt, fs_cnt, max_hp, max_vp, dbl_ls;
   logic prev_ls;
   // Default-instance measurements.
   int f_ls1, f_ls2, f_hlo, f_hlo_first, f_fs, f_vlo;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 12'h000, 0, 1, 1, 0);
      // k = Clk edges since reset release with enable=1 and pixel_rgb=FF8040.
      vecs[0]  = '{0,    idle};
      vecs[1]  = '{1,    idle};
      vecs[2]  = '{2,    mk(0, 0, 0, 0, 0, 12'h000, 0, 1, 1, 1)};
      vecs[3]  = '{3,    mk(0, 0, 0, 0, 0, 12'h000, 0, 1, 1, 1)};
      vecs[4]  = '{4,    idle};
      vecs[5]  = '{17,   mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 1, 0)};
      vecs[6]  = '{32,   mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 1, 0)};
      vecs[7]  = '{33,   idle};
      vecs[8]  = '{160,  mk(0, 0, 0, 1, 0, 12'h000, 0, 1, 1, 0)};
      vecs[9]  = '{161,  idle};
      vecs[10] = '{321,  mk(0, 0, 0, 0, 0, 12'h000, 0, 1, 0, 0)};
      vecs[11] = '{840,  mk(0, 0, 1, 0, 0, 12'h000, 0, 1, 1, 0)};
      vecs[12] = '{841,  mk(0, 0, 1, 0, 0, 12'h040, 1, 1, 1, 0)};
      vecs[13] = '{842,  mk(0, 0, 1, 0, 0, 12'h040, 1, 1, 1, 1)};
      vecs[14] = '{843,  mk(0, 0, 1, 0, 0, 12'hFF8, 1, 1, 1, 1)};
      vecs[15] = '{844,  mk(1, 0, 1, 0, 0, 12'hFF8, 1, 1, 1, 0)};
      vecs[16] = '{1916, mk(29, 6, 1, 0, 0, 12'hFF8, 1, 1, 1, 0)};
      vecs[17] = '{1917, mk(29, 6, 1, 0, 0, 12'h040, 1, 1, 1, 0)};
      vecs[18] = '{1920, mk(0, 0, 0, 1, 1, 12'hFF8, 1, 1, 1, 0)};
      vecs[19] = '{1921, idle};

      Reset_n   = 1'b0;
      enable    = 1'b1;
      pixel_rgb = 24'hFF8040;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;

      fork
         begin
            check_outs("vec k=0", vecs[0].exp);
            idx = 1;
            de_cnt = 0; h_lo = 0; v_lo = 0; ls_cnt = 0; fs_cnt = 0;
            max_hp = 0; max_vp = 0; dbl_ls = 0; prev_ls = 1'b0;
            for (int k = 1; k <= 3840; k++) begin
               @(negedge Clk);
               if (idx < NVEC && vecs[idx].k == k) begin
                  check_outs($sformatf("vec k=%0d", k), vecs[idx].exp);
                  idx++;
               end
               if (k >= 1921) begin
                  if (dvi_de) de_cnt++;
                  if (!dvi_h) h_lo++;
                  if (!dvi_v) v_lo++;
                  if (line_start) ls_cnt++;
                  if (frame_start) fs_cnt++;
                  if (line_start && prev_ls) dbl_ls++;
                  if (int'(hpos) > max_hp) max_hp = int'(hpos);
                  if (int'(vpos) > max_vp) max_vp = int'(vpos);
               end
               prev_ls = line_start;
            end
            check_int("vectors applied", idx, NVEC);
            check_int("DE cycles per frame", de_cnt, 840);
            check_int("HSYNC low cycles per frame", h_lo, 192);
            check_int("VSYNC low cycles per frame", v_lo, 320);
            check_int("line_start pulses per frame", ls_cnt, 12);
            check_int("frame_start pulses per frame", fs_cnt, 1);
            check_int("line_start wider than 1 Clk", dbl_ls, 0);
            check_int("max hpos", max_hp, 29);
            check_int("max vpos", max_vp, 6);
         end
         begin
            f_ls1 = -1; f_ls2 = -1; f_hlo = 0; f_hlo_first = -1; f_fs = 0; f_vlo = 0;
            for (int c = 1; c <= 6500; c++) begin
               @(negedge Clk);
               if (f_line_start) begin
                  if (f_ls1 < 0) f_ls1 = c;
                  else if (f_ls2 < 0) f_ls2 = c;
               end
               if (!f_dvi_h && c <= 3200) begin
                  f_hlo++;
                  if (f_hlo_first < 0) f_hlo_first = c;
               end
               if (f_frame_start) f_fs++;
               if (!f_dvi_v) f_vlo++;
            end
            check_int("640x480 first line_start", f_ls1, 3200);
            check_int("640x480 second line_start", f_ls2, 6400);
            check_int("640x480 HSYNC low cycles", f_hlo, 384);
            check_int("640x480 HSYNC first low edge", f_hlo_first, 65);
            check_int("640x480 early frame_start", f_fs, 0);
            check_int("640x480 early VSYNC low", f_vlo, 0);
         end
      join

      // Clean origin, then run to pixel (20,8) inside the image.
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int k = 1; k <= 1361; k++) @(negedge Clk);
      check_outs("mid-image before reset", mk(10, 3, 1, 0, 0, 12'h040, 1, 1, 1, 0));
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1 check_outs("async reset mid-frame", idle);
      @(negedge Clk);
      Reset_n = 1'b1;
      check_restart("after reset");

      // Continue to pixel (5,2): inside both sync pulses.
      for (int k = 161; k <= 341; k++) @(negedge Clk);
      check_outs("in H+V sync before disable", mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0));
      enable = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clk);
         check_outs($sformatf("disabled cycle %0d", i), idle);
      end
      enable = 1'b1;
      check_restart("after re-enable");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
